pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and widths for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int FLUSH_CNT_W = 3;
    localparam int WAIT_CNT_W  = 8;

    typedef enum logic [1:0] {
        RUN,
        DMEM_WAIT,
        FLUSH,
        FAULT
    } state_t;

    typedef struct packed {
        logic pc_write_en;
        logic pc_redirect;
        logic if_id_write_en;
        logic if_id_flush;
        logic id_ex_write_en;
        logic id_ex_bubble;
        logic ex_mem_write_en;
        logic mem_wb_bubble;
        logic fault;
    } ctrl_t;

    // Output patterns, one per distinct pipe action
    localparam ctrl_t CTRL_RESET  = 9'b000101010;
    localparam ctrl_t CTRL_RUN    = 9'b101010100;
    localparam ctrl_t CTRL_STALL  = 9'b000011100;
    localparam ctrl_t CTRL_REDIR  = 9'b111111100;
    localparam ctrl_t CTRL_FLUSH  = 9'b101111100;
    localparam ctrl_t CTRL_HOLD   = 9'b000000010;
    localparam ctrl_t CTRL_FAULT  = 9'b000101011;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stage-register controls between pipe and controller
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  dmem_busy;

    logic pc_write_en;
    logic pc_redirect;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_write_en;
    logic id_ex_bubble;
    logic ex_mem_write_en;
    logic mem_wb_bubble;
    logic fault;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
        input  pc_write_en, pc_redirect, if_id_write_en, if_id_flush,
        input  id_ex_write_en, id_ex_bubble, ex_mem_write_en, mem_wb_bubble, fault
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
        output pc_write_en, pc_redirect, if_id_write_en, if_id_flush,
        output id_ex_write_en, id_ex_bubble, ex_mem_write_en, mem_wb_bubble, fault
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/hold sequencing for 5-stage pipe registers
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_cycles counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clock,
    input  logic                    resetn,
    pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_cycles
`endif
);

    state_t                 state, nxt_state;
    logic [FLUSH_CNT_W-1:0] flush_cnt, nxt_flush_cnt;
    logic [WAIT_CNT_W-1:0]  wait_cnt, nxt_wait_cnt;
    logic                   pending_redirect, nxt_pending_redirect;
    logic                   load_use;
    ctrl_t                  ctrl;

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT   = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam state_t                 REDIR_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    hazard_detect u_hazard_detect (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs1 (hz.id_uses_rs1),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rd       (hz.ex_rd),
        .load_use    (load_use)
    );

    always_comb begin
        ctrl                 = CTRL_RUN;
        nxt_state            = state;
        nxt_flush_cnt        = flush_cnt;
        nxt_wait_cnt         = wait_cnt;
        nxt_pending_redirect = pending_redirect;

        case (state)
            RUN, FLUSH: begin
                if (hz.dmem_busy) begin
                    ctrl                 = CTRL_HOLD;
                    nxt_wait_cnt         = WAIT_CNT_W'(1);
                    nxt_pending_redirect = hz.ex_branch_taken;
                    nxt_state            = DMEM_WAIT;
                end else if (hz.ex_branch_taken) begin
                    ctrl          = CTRL_REDIR;
                    nxt_flush_cnt = FLUSH_RELOAD;
                    nxt_state     = REDIR_NEXT;
                end else if (state == FLUSH) begin
                    // ID holds a wrong-path instruction here, so load-use is moot
                    ctrl          = CTRL_FLUSH;
                    nxt_flush_cnt = flush_cnt - 1'b1;
                    if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                        nxt_state = RUN;
                    end
                end else if (load_use) begin
                    ctrl = CTRL_STALL;
                end
            end

            DMEM_WAIT: begin
                if (hz.dmem_busy) begin
                    ctrl                 = CTRL_HOLD;
                    nxt_pending_redirect = pending_redirect || hz.ex_branch_taken;
                    if (wait_cnt >= WAIT_LIMIT) begin
                        nxt_state = FAULT;
                    end else if (wait_cnt != '1) begin
                        nxt_wait_cnt = wait_cnt + 1'b1;
                    end
                end else begin
                    nxt_wait_cnt         = '0;
                    nxt_pending_redirect = 1'b0;
                    if (pending_redirect || hz.ex_branch_taken) begin
                        ctrl          = CTRL_REDIR;
                        nxt_flush_cnt = FLUSH_RELOAD;
                        nxt_state     = REDIR_NEXT;
                    end else begin
                        if (load_use) begin
                            ctrl = CTRL_STALL;
                        end
                        nxt_state = RUN;
                    end
                end
            end

            default: begin
                ctrl = CTRL_FAULT;
            end
        endcase

        // Reset forces safe controls in the same cycle, not just after the next edge
        if (!resetn) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= RUN;
            flush_cnt        <= '0;
            wait_cnt         <= '0;
            pending_redirect <= 1'b0;
        end else begin
            state            <= nxt_state;
            flush_cnt        <= nxt_flush_cnt;
            wait_cnt         <= nxt_wait_cnt;
            pending_redirect <= nxt_pending_redirect;
        end
    end

    assign hz.pc_write_en     = ctrl.pc_write_en;
    assign hz.pc_redirect     = ctrl.pc_redirect;
    assign hz.if_id_write_en  = ctrl.if_id_write_en;
    assign hz.if_id_flush     = ctrl.if_id_flush;
    assign hz.id_ex_write_en  = ctrl.id_ex_write_en;
    assign hz.id_ex_bubble    = ctrl.id_ex_bubble;
    assign hz.ex_mem_write_en = ctrl.ex_mem_write_en;
    assign hz.mem_wb_bubble   = ctrl.mem_wb_bubble;
    assign hz.fault           = ctrl.fault;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (state != FAULT) begin
            if (!ctrl.pc_write_en) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ctrl.if_id_flush) begin
                flush_cycles <= flush_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (15)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .hz     (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    // {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble, fault}
    localparam logic [8:0] E_RST   = 9'b000101010;
    localparam logic [8:0] E_RUN   = 9'b101010100;
    localparam logic [8:0] E_STALL = 9'b000011100;
    localparam logic [8:0] E_REDIR = 9'b111111100;
    localparam logic [8:0] E_FLUSH = 9'b101111100;
    localparam logic [8:0] E_HOLD  = 9'b000000010;
    localparam logic [8:0] E_FLT   = 9'b000101011;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_stall  = 0;
    logic [31:0] m_flush  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic busy);
        hz.ex_mem_read     = ld;
        hz.ex_rd           = rd;
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.id_uses_rs1     = u1;
        hz.id_uses_rs2     = u2;
        hz.ex_branch_taken = br;
        hz.dmem_busy       = busy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are driven just after a falling edge; check mid-low phase, then advance one cycle
    task automatic cyc(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        #1;
        got = {hz.pc_write_en, hz.pc_redirect, hz.if_id_write_en, hz.if_id_flush,
               hz.id_ex_write_en, hz.id_ex_bubble, hz.ex_mem_write_en, hz.mem_wb_bubble, hz.fault};
        check_eq(tag, {23'd0, got}, {23'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, "_stall_cnt"}, stall_cycles, m_stall);
        check_eq({tag, "_flush_cnt"}, flush_cycles, m_flush);
`endif
        if (!resetn) begin
            m_stall = 0;
            m_flush = 0;
        end else if (exp != E_FLT) begin
            if (!exp[8]) m_stall = m_stall + 1;
            if (exp[5])  m_flush = m_flush + 1;
        end
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        @(negedge clock);
        cyc("reset", E_RST);
        resetn = 1'b1;
        cyc("run_idle", E_RUN);

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs1", E_STALL);
        idle();
        cyc("lu_release", E_RUN);
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lu_rs2", E_STALL);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_x0", E_RUN);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_unused", E_RUN);
        drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_not_load", E_RUN);

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("br_over_lu", E_REDIR);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("flush2_lu_ignored", E_FLUSH);
        idle();
        cyc("flush_done", E_RUN);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("wait1", E_HOLD);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("wait2_br", E_HOLD);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("wait3", E_HOLD);
        idle();
        cyc("wait_release_redir", E_REDIR);
        cyc("wait_flush", E_FLUSH);
        cyc("wait_back_run", E_RUN);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("br_again", E_REDIR);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("br_restart", E_REDIR);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("flush_to_hold", E_HOLD);
        idle();
        cyc("hold_release_no_redir", E_RUN);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("timeout_hold%0d", i), E_HOLD);
        end
        idle();
        cyc("fault", E_FLT);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("fault_sticky", E_FLT);
        idle();
        resetn = 1'b0;
        cyc("fault_reset", E_RST);
        resetn = 1'b1;
        cyc("fault_cleared", E_RUN);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("br_pre_reset", E_REDIR);
        idle();
        resetn = 1'b0;
        cyc("reset_in_flush", E_RST);
        resetn = 1'b1;
        cyc("after_flush_reset", E_RUN);
        drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lu_after_reset", E_STALL);
        idle();
        cyc("final_run", E_RUN);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
